// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage pipeline controller.
// Owns the program counter and the IF/ID / ID/EX control strobes. It stalls
// on data hazards and freezes fetch while a branch/call/return is
// unresolved. It redirects the PC on resolution and pulses the matching
// clr_*_haz to release the hazard detector's latch.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   data_hazard, control_hazard   hazard detector outputs
//   branch_id, call_id, ret_id    class of the instruction in ID
//   *_resolve, branch_taken,
//   *_target                      resolution from later stages
//   pc                            fetch address (registered)
//   ifid_en, ifid_flush           IF/ID load enable / NOP insert
//   idex_bubble                   ID/EX NOP insert
//   clr_branch_haz, clr_call_haz,
//   clr_ret_haz                   single-cycle latch clear pulses
//   timeout                       sticky: a control wait exceeded MAX_WAIT
module fetch_ctrl #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_hazard,
  input  logic            control_hazard,
  input  logic            branch_id,
  input  logic            call_id,
  input  logic            ret_id,
  input  logic            branch_resolve,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call_resolve,
  input  logic [PC_W-1:0] call_target,
  input  logic            ret_resolve,
  input  logic [PC_W-1:0] ret_target,
  output logic [PC_W-1:0] pc,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            clr_branch_haz,
  output logic            clr_call_haz,
  output logic            clr_ret_haz,
  output logic            timeout
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN, WAIT_BR, WAIT_CALL, WAIT_RET} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_d;
  logic             timeout_d;

  // Resolution view of the class currently being waited on
  logic             resolve;
  logic             load;
  logic [PC_W-1:0]  target;
  logic             clr_hit;

  // State, counter, PC and sticky timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc      <= RESET_PC;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc      <= pc_d;
      timeout <= timeout_d;
    end
  end

  // Next-state, PC update and combinational strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc;
    timeout_d   = timeout;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    resolve     = 1'b0;
    load        = 1'b0;
    target      = pc;
    clr_hit     = 1'b0;

    // Only the resolve of the awaited class is looked at
    case (state_q)
      WAIT_BR: begin
        resolve = branch_resolve;
        load    = branch_taken;
        target  = branch_target;
      end
      WAIT_CALL: begin
        resolve = call_resolve;
        load    = 1'b1;
        target  = call_target;
      end
      WAIT_RET: begin
        resolve = ret_resolve;
        load    = 1'b1;
        target  = ret_target;
      end
      default: ;
    endcase

    case (state_q)
      RUN: begin
        if (data_hazard) begin
          // Instruction stays in ID; control classes are not acted on yet
          idex_bubble = 1'b1;
        end else if (branch_id || call_id || ret_id) begin
          // PC already holds the fall-through address; keep it
          ifid_flush = 1'b1;
          cnt_d      = '0;
          if (branch_id)    state_d = WAIT_BR;
          else if (call_id) state_d = WAIT_CALL;
          else              state_d = WAIT_RET;
        end else if (control_hazard) begin
          // Detector sees a control hazard the decode class did not: hold
          ifid_flush = 1'b1;
        end else begin
          ifid_en = 1'b1;
          pc_d    = pc + PC_W'(1);
        end
      end
      default: begin
        ifid_flush = 1'b1;
        if (resolve) begin
          clr_hit = 1'b1;
          state_d = RUN;
          if (load) pc_d = target;
        end else if (cnt_q == CNT_LAST) begin
          clr_hit   = 1'b1;
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    clr_branch_haz = clr_hit && (state_q == WAIT_BR);
    clr_call_haz   = clr_hit && (state_q == WAIT_CALL);
    clr_ret_haz    = clr_hit && (state_q == WAIT_RET);
  end

endmodule
